// File: rtl/ldpc_3gpp_enc_source_pbuf.sv
// Source packer for the LDPC encoder: packs input samples into buffer words, pads short
// frames with zero words up to the latched length, and tracks downstream buffer occupancy.
module ldpc_3gpp_enc_source_pbuf #(
  parameter int unsigned pIN_W   = 8,
  parameter int unsigned pPACK   = 4,
  parameter int unsigned pADDR_W = 8,
  parameter int unsigned pBUF_N  = 2,
  localparam int unsigned pWORD_W = pIN_W * pPACK,
  localparam int unsigned pBUF_W  = (pBUF_N > 1) ? $clog2(pBUF_N) : 1
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               isop,
  input  logic               ieop,
  input  logic               ival,
  input  logic [pIN_W-1:0]   idat,
  input  logic [pADDR_W-1:0] ilen,
  input  logic               ibuf_free,
  output logic               ordy,
  output logic               obusy,
  output logic               owrite,
  output logic               owfull,
  output logic [pBUF_W-1:0]  owbuf,
  output logic [pADDR_W-1:0] owaddr,
  output logic [pWORD_W-1:0] owdat,
  output logic               oerr
);

  localparam int unsigned PW = (pPACK > 1) ? $clog2(pPACK) : 1;
  localparam int unsigned UW = $clog2(pBUF_N + 1);

  typedef enum logic [1:0] {StIdle, StFill, StPad} state_e;

  state_e               state_q, state_d;
  logic [pADDR_W-1:0]   len_q, len_d;
  logic [pADDR_W-1:0]   widx_q, widx_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [pWORD_W-1:0]   pack_q, pack_d;
  // over: word ilen already written; dropped: overflow error already reported
  logic                 over_q, over_d;
  logic                 dropped_q, dropped_d;
  logic [pBUF_W-1:0]    wbuf_q, wbuf_d;
  logic [UW-1:0]        used_q, used_d;
  logic                 write_q, write_d;
  logic                 full_q, full_d;
  logic                 err_q, err_d;
  logic [pADDR_W-1:0]   waddr_q, waddr_d;
  logic [pWORD_W-1:0]   wdat_q, wdat_d;

  logic                 acc, sop, last, flush, free_ok, free_err;
  logic [PW-1:0]        lane;
  logic [pADDR_W-1:0]   idx, flen;
  logic [pWORD_W-1:0]   word;

  // State register
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      widx_q    <= '0;
      pcnt_q    <= '0;
      pack_q    <= '0;
      over_q    <= 1'b0;
      dropped_q <= 1'b0;
      wbuf_q    <= '0;
      used_q    <= '0;
      write_q   <= 1'b0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      waddr_q   <= '0;
      wdat_q    <= '0;
    end else if (iclkena) begin
      state_q   <= state_d;
      len_q     <= len_d;
      widx_q    <= widx_d;
      pcnt_q    <= pcnt_d;
      pack_q    <= pack_d;
      over_q    <= over_d;
      dropped_q <= dropped_d;
      wbuf_q    <= wbuf_d;
      used_q    <= used_d;
      write_q   <= write_d;
      full_q    <= full_d;
      err_q     <= err_d;
      waddr_q   <= waddr_d;
      wdat_q    <= wdat_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    pcnt_d    = pcnt_q;
    pack_d    = pack_q;
    over_d    = over_q;
    dropped_d = dropped_q;
    write_d   = 1'b0;
    full_d    = 1'b0;
    err_d     = 1'b0;
    waddr_d   = waddr_q;
    wdat_d    = wdat_q;

    acc  = ival & ordy;
    sop  = acc & isop;
    // An accepted isop behaves as a fresh frame start whether in IDLE or FILL
    lane = sop ? '0 : pcnt_q;
    idx  = sop ? '0 : widx_q;
    flen = sop ? ilen : len_q;
    word = sop ? '0 : pack_q;
    word[int'(lane)*pIN_W +: pIN_W] = idat;
    last  = (idx == flen);
    flush = (lane == PW'(pPACK - 1)) | ieop;

    unique case (state_q)
      StPad: begin
        write_d = 1'b1;
        waddr_d = widx_q;
        wdat_d  = '0;
        full_d  = (widx_q == len_q);
        if (widx_q == len_q) state_d = StIdle;
        else                 widx_d  = widx_q + 1'b1;
      end
      default: begin
        if (acc) begin
          if (state_q == StIdle && !isop) begin
            err_d = 1'b1;
          end else if (!sop && over_q) begin
            err_d     = ~dropped_q;
            dropped_d = 1'b1;
            if (ieop) state_d = StIdle;
          end else begin
            if (sop && state_q == StFill) err_d = 1'b1;
            len_d     = flen;
            over_d    = 1'b0;
            dropped_d = 1'b0;
            if (flush) begin
              write_d = 1'b1;
              waddr_d = idx;
              wdat_d  = word;
              full_d  = last;
              pack_d  = '0;
              pcnt_d  = '0;
              widx_d  = idx;
              if (last) begin
                over_d  = 1'b1;
                state_d = ieop ? StIdle : StFill;
              end else begin
                widx_d  = idx + 1'b1;
                state_d = ieop ? StPad : StFill;
              end
            end else begin
              pack_d  = word;
              pcnt_d  = lane + 1'b1;
              widx_d  = idx;
              state_d = StFill;
            end
          end
        end
      end
    endcase

    free_ok  = ibuf_free & (used_q != '0);
    free_err = ibuf_free & (used_q == '0);
    if (free_err) err_d = 1'b1;

    // A completed buffer and a release in the same cycle cancel out
    used_d = used_q;
    if (full_d && !free_ok)      used_d = used_q + 1'b1;
    else if (!full_d && free_ok) used_d = used_q - 1'b1;

    wbuf_d = wbuf_q;
    if (full_q) wbuf_d = (wbuf_q == pBUF_W'(pBUF_N - 1)) ? '0 : wbuf_q + 1'b1;
  end

  // Outputs
  always_comb begin
    ordy   = (state_q != StPad) && (used_q != UW'(pBUF_N));
    obusy  = (state_q != StIdle) || (used_q != '0);
    owrite = write_q;
    owfull = full_q;
    owbuf  = wbuf_q;
    owaddr = waddr_q;
    owdat  = wdat_q;
    oerr   = err_q;
  end

endmodule

// File: tb/tb_ldpc_3gpp_enc_source_pbuf.sv
// Directed bench for ldpc_3gpp_enc_source_pbuf at default parameters.
module tb_ldpc_3gpp_enc_source_pbuf;

  logic        iclk = 1'b0;
  logic        ireset, iclkena, isop, ieop, ival, ibuf_free;
  logic [7:0]  idat, ilen;
  logic        ordy, obusy, owrite, owfull, oerr;
  logic [0:0]  owbuf;
  logic [7:0]  owaddr;
  logic [31:0] owdat;

  int tests = 0;
  int fails = 0;

  // Write log and error pulse counter
  logic [7:0]  la [0:63];
  logic [31:0] ld [0:63];
  logic        lf [0:63];
  logic [0:0]  lb [0:63];
  int wn = 0;
  int nerr = 0;

  ldpc_3gpp_enc_source_pbuf dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .iclkena   (iclkena),
    .isop      (isop),
    .ieop      (ieop),
    .ival      (ival),
    .idat      (idat),
    .ilen      (ilen),
    .ibuf_free (ibuf_free),
    .ordy      (ordy),
    .obusy     (obusy),
    .owrite    (owrite),
    .owfull    (owfull),
    .owbuf     (owbuf),
    .owaddr    (owaddr),
    .owdat     (owdat),
    .oerr      (oerr)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) begin
    #2;
    if (owrite && wn < 64) begin
      la[wn] = owaddr;
      ld[wn] = owdat;
      lf[wn] = owfull;
      lb[wn] = owbuf;
      wn++;
    end
    if (oerr) nerr++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e, input logic f);
    ival = 1'b1; idat = d; isop = s; ieop = e; ibuf_free = f;
    @(negedge iclk);
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; ibuf_free = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] first, input int n, input logic [7:0] len);
    ilen = len;
    for (int i = 0; i < n; i++) send(first + 8'(i), i == 0, i == n - 1, 1'b0);
  endtask

  task automatic free_buf();
    ibuf_free = 1'b1;
    @(negedge iclk);
    ibuf_free = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (ordy !== 1'b1) begin fails++; $display("FAIL reset_ordy got %b want 1", ordy); end
    tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL reset_obusy got %b want 0", obusy); end
    tests++; if ({owrite, owfull, oerr} !== 3'b000) begin
      fails++; $display("FAIL reset_pulses got %b want 000", {owrite, owfull, oerr}); end
    tests++; if ({owbuf, owaddr, owdat} !== 41'd0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h want 0", owbuf, owaddr, owdat); end
  endtask

  task automatic test_full_frame();
    logic [31:0] ed [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    int s = wn;
    int e0 = nerr;
    send_frame(8'h00, 16, 8'd3);
    tick(2);
    tests++; if (wn - s !== 4) begin fails++; $display("FAIL full_count got %0d want 4", wn - s); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({la[s+i], ld[s+i], lf[s+i], lb[s+i]} !== {8'(i), ed[i], i == 3, 1'b0}) begin
        fails++;
        $display("FAIL full_word%0d got a=%h d=%h f=%b b=%b want a=%0d d=%h f=%b b=0",
                 i, la[s+i], ld[s+i], lf[s+i], lb[s+i], i, ed[i], i == 3);
      end
    end
    tests++; if (nerr - e0 !== 0) begin fails++; $display("FAIL full_err got %0d want 0", nerr - e0); end
    tests++; if ({ordy, obusy} !== 2'b11) begin
      fails++; $display("FAIL full_after got ordy/obusy=%b want 11", {ordy, obusy}); end
    free_buf();
  endtask

  task automatic test_pad();
    logic [31:0] ed [4] = '{32'h14131211, 32'h00000015, 32'h0, 32'h0};
    int s = wn;
    send_frame(8'h11, 5, 8'd3);
    tests++; if (ordy !== 1'b0) begin fails++; $display("FAIL pad_ordy got %b want 0", ordy); end
    tick(3);
    tests++; if (wn - s !== 4) begin fails++; $display("FAIL pad_count got %0d want 4", wn - s); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({la[s+i], ld[s+i], lf[s+i], lb[s+i]} !== {8'(i), ed[i], i == 3, 1'b1}) begin
        fails++;
        $display("FAIL pad_word%0d got a=%h d=%h f=%b b=%b want a=%0d d=%h f=%b b=1",
                 i, la[s+i], ld[s+i], lf[s+i], lb[s+i], i, ed[i], i == 3);
      end
    end
    tests++; if (ordy !== 1'b1) begin fails++; $display("FAIL pad_ordy_end got %b want 1", ordy); end
    free_buf();
  endtask

  task automatic test_buffers_full();
    int s = wn;
    int e0 = nerr;
    send_frame(8'hA0, 4, 8'd0);
    send_frame(8'hB0, 4, 8'd0);
    tests++; if ({ordy, obusy} !== 2'b01) begin
      fails++; $display("FAIL bufs_full got ordy/obusy=%b want 01", {ordy, obusy}); end
    send_frame(8'hC0, 4, 8'd0);
    tick(1);
    tests++; if (wn - s !== 2) begin fails++; $display("FAIL bufs_blocked got %0d want 2", wn - s); end
    tests++; if (nerr - e0 !== 0) begin fails++; $display("FAIL bufs_err got %0d want 0", nerr - e0); end
    tests++; if ({lb[s], lb[s+1]} !== 2'b01) begin
      fails++; $display("FAIL bufs_ids got %b want 01", {lb[s], lb[s+1]}); end
    free_buf();
    tests++; if (ordy !== 1'b1) begin fails++; $display("FAIL bufs_freed got %b want 1", ordy); end
    send_frame(8'hD0, 4, 8'd0);
    tick(1);
    tests++; if ({la[s+2], ld[s+2], lf[s+2], lb[s+2]} !== {8'd0, 32'hD3D2D1D0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL bufs_wrap got a=%h d=%h f=%b b=%b want a=0 d=d3d2d1d0 f=1 b=0",
                        la[s+2], ld[s+2], lf[s+2], lb[s+2]); end
    free_buf();
    free_buf();
  endtask

  task automatic test_overflow();
    int s = wn;
    int e0 = nerr;
    send_frame(8'h20, 12, 8'd1);
    tick(2);
    tests++; if (wn - s !== 2) begin fails++; $display("FAIL ovf_count got %0d want 2", wn - s); end
    tests++; if ({la[s], ld[s], lf[s]} !== {8'd0, 32'h23222120, 1'b0}) begin
      fails++; $display("FAIL ovf_word0 got a=%h d=%h f=%b", la[s], ld[s], lf[s]); end
    tests++; if ({la[s+1], ld[s+1], lf[s+1], lb[s+1]} !== {8'd1, 32'h27262524, 1'b1, 1'b1}) begin
      fails++; $display("FAIL ovf_word1 got a=%h d=%h f=%b b=%b", la[s+1], ld[s+1], lf[s+1], lb[s+1]); end
    tests++; if (nerr - e0 !== 1) begin fails++; $display("FAIL ovf_err got %0d want 1", nerr - e0); end
    free_buf();
    tests++; if ({ordy, obusy} !== 2'b10) begin
      fails++; $display("FAIL ovf_idle got ordy/obusy=%b want 10", {ordy, obusy}); end
  endtask

  task automatic test_abort();
    logic [7:0]  ea [3] = '{8'd0, 8'd0, 8'd1};
    logic [31:0] ed [3] = '{32'h33323130, 32'h43424140, 32'h47464544};
    int s, e0;
    send_frame(8'h01, 4, 8'd0);
    s = wn;
    e0 = nerr;
    ilen = 8'd1;
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), i == 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), i == 0, i == 7, i == 7);
    tick(2);
    tests++; if (wn - s !== 3) begin fails++; $display("FAIL abort_count got %0d want 3", wn - s); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({la[s+i], ld[s+i], lf[s+i], lb[s+i]} !== {ea[i], ed[i], i == 2, 1'b1}) begin
        fails++;
        $display("FAIL abort_word%0d got a=%h d=%h f=%b b=%b want a=%h d=%h f=%b b=1",
                 i, la[s+i], ld[s+i], lf[s+i], lb[s+i], ea[i], ed[i], i == 2);
      end
    end
    tests++; if (nerr - e0 !== 1) begin fails++; $display("FAIL abort_err got %0d want 1", nerr - e0); end
    tests++; if ({ordy, obusy} !== 2'b11) begin
      fails++; $display("FAIL abort_used got ordy/obusy=%b want 11", {ordy, obusy}); end
    free_buf();
    tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL abort_free got %b want 0", obusy); end
  endtask

  task automatic test_clkena();
    int s = wn;
    ilen = 8'd0;
    send(8'h70, 1'b1, 1'b0, 1'b0);
    send(8'h71, 1'b0, 1'b0, 1'b0);
    iclkena = 1'b0; ival = 1'b1; isop = 1'b1; idat = 8'hEE;
    tick(3);
    iclkena = 1'b1; ival = 1'b0; isop = 1'b0;
    send(8'h72, 1'b0, 1'b0, 1'b0);
    send(8'h73, 1'b0, 1'b1, 1'b0);
    tick(1);
    tests++; if (wn - s !== 1) begin fails++; $display("FAIL clkena_count got %0d want 1", wn - s); end
    tests++; if ({ld[s], lf[s], lb[s]} !== {32'h73727170, 1'b1, 1'b0}) begin
      fails++; $display("FAIL clkena_word got d=%h f=%b b=%b want 73727170/1/0", ld[s], lf[s], lb[s]); end
    free_buf();
  endtask

  task automatic test_reset_pad();
    int s, e0;
    ilen = 8'd7;
    send(8'h55, 1'b1, 1'b1, 1'b0);
    tick(1);
    tests++; if (ordy !== 1'b0) begin fails++; $display("FAIL rpad_ordy got %b want 0", ordy); end
    #2 ireset = 1'b1;
    #1;
    tests++; if ({owrite, owfull, oerr, owbuf} !== 4'b0000) begin
      fails++; $display("FAIL rpad_pulses got %b want 0000", {owrite, owfull, oerr, owbuf}); end
    tests++; if ({owaddr, owdat} !== 40'd0) begin
      fails++; $display("FAIL rpad_data got %h/%h want 0", owaddr, owdat); end
    tests++; if ({ordy, obusy} !== 2'b10) begin
      fails++; $display("FAIL rpad_rdy got ordy/obusy=%b want 10", {ordy, obusy}); end
    @(negedge iclk);
    ireset = 1'b0;
    tick(1);
    s = wn;
    send_frame(8'h60, 4, 8'd0);
    tick(1);
    tests++; if (wn - s !== 1) begin fails++; $display("FAIL rpad_count got %0d want 1", wn - s); end
    tests++; if ({la[s], ld[s], lf[s], lb[s]} !== {8'd0, 32'h63626160, 1'b1, 1'b0}) begin
      fails++; $display("FAIL rpad_next got a=%h d=%h f=%b b=%b want 0/63626160/1/0",
                        la[s], ld[s], lf[s], lb[s]); end
    free_buf();
    e0 = nerr;
    free_buf();
    tick(1);
    tests++; if (nerr - e0 !== 1) begin fails++; $display("FAIL free_empty_err got %0d want 1", nerr - e0); end
    tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL free_empty_busy got %b want 0", obusy); end
  endtask

  initial begin
    ireset = 1'b1; iclkena = 1'b1; isop = 1'b0; ieop = 1'b0; ival = 1'b0;
    ibuf_free = 1'b0; idat = '0; ilen = '0;
    tick(3);
    test_reset();
    ireset = 1'b0;
    tick(1);
    test_full_frame();
    test_pad();
    test_buffers_full();
    test_overflow();
    test_abort();
    test_clkena();
    test_reset_pad();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
